ex_alu_muldiv_ctrl: RTL and testbench

Next-generation EX-stage ALU control for the MIPS32 pipeline. It keeps the combinational ALUOp/funct decode to a 4-bit ALU control code and extends it with NOR and XOR. It adds an iterative MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers and stalls the pipeline while it runs. It sits beside the EX ALU, drives the hazard unit's stall input, and feeds HI/LO to the EX result mux for MFHI/MFLO.

---
 rtl/ex_alu_pkg.sv | 36 +++
 rtl/ex_muldiv_iter.sv | 23 ++
 rtl/ex_alu_muldiv_ctrl.sv | 114 +++++++++++
 tb/tb_ex_alu_muldiv_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ex_alu_pkg.sv
// ex_alu_pkg: ALU control codes, ALUOp/funct encodings and mul/div sequencer states
package ex_alu_pkg;
  localparam logic [3:0] ALUadd = 4'b0010;
  localparam logic [3:0] ALUsub = 4'b0110;
  localparam logic [3:0] ALUand = 4'b0000;
  localparam logic [3:0] ALUor  = 4'b0001;
  localparam logic [3:0] ALUslt = 4'b0111;
  localparam logic [3:0] ALUnor = 4'b1100;
  localparam logic [3:0] ALUxor = 4'b1101;
  localparam logic [3:0] ALUx   = 4'b0011;
  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BEQ = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_X   = 2'b11;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [1:0] SEL_ALU = 2'b00;
  localparam logic [1:0] SEL_HI  = 2'b01;
  localparam logic [1:0] SEL_LO  = 2'b10;
  typedef enum logic [1:0] {IDLE, RUN, DONE} md_state_t;
  // mult, multu, div, divu share funct[5:2] = 0110
  function automatic logic is_muldiv(input logic [5:0] f);
    return f[5:2] == 4'b0110;
  endfunction
endpackage

// File: rtl/ex_muldiv_iter.sv
// ex_muldiv_iter: one shift-add multiply or restoring divide step
module ex_muldiv_iter #(
  parameter int DATA_W = 32
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [2*DATA_W-1:0]   mc,
  input  logic [DATA_W-1:0]     mq,
  output logic [2*DATA_W-1:0]   acc_n,
  output logic [2*DATA_W-1:0]   mc_n,
  output logic [DATA_W-1:0]     mq_n
);
  logic [DATA_W:0] rem_sh, diff;
  // divide: acc low half is the remainder, mq shifts dividend out and quotient in
  always_comb begin
    rem_sh = {acc[DATA_W-1:0], mq[DATA_W-1]};
    diff   = rem_sh - {1'b0, mc[DATA_W-1:0]};
    acc_n  = is_div ? {{DATA_W{1'b0}}, diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0]}
                    : acc + (mq[0] ? mc : '0);
    mc_n   = is_div ? mc : mc << 1;
    mq_n   = is_div ? {mq[DATA_W-2:0], ~diff[DATA_W]} : mq >> 1;
  end
endmodule

// File: rtl/ex_alu_muldiv_ctrl.sv
// ex_alu_muldiv_ctrl: ALU control decode plus iterative mul/div sequencer owning HI/LO; MULDIV_EARLY_OUT_EN enables multiply early exit
module ex_alu_muldiv_ctrl
  import ex_alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Valid_EX,
  input  logic              Advance_EX,
  input  logic [1:0]        ALUOp_EX,
  input  logic [5:0]        Funct_EX,
  input  logic [DATA_W-1:0] Operand_A_EX,
  input  logic [DATA_W-1:0] Operand_B_EX,
  output logic [3:0]        ALU_Control_EX,
  output logic [1:0]        HiLo_Sel_EX,
  output logic              MulDiv_Busy_EX,
  output logic              MulDiv_Done_EX,
  output logic              DivByZero_EX,
  output logic [DATA_W-1:0] HI_EX,
  output logic [DATA_W-1:0] LO_EX
);
  md_state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [3:0] r_ctrl;
  logic start, is_signed, last, is_div, sign_a, neg_q, dz, done_r;
  logic [2*DATA_W-1:0] acc, mc, acc_n, mc_n, prod;
  logic [DATA_W-1:0] mq, mq_n, mag_a, mag_b, hi, lo, res_hi, res_lo;
  always_comb begin
    case (Funct_EX)
      F_ADD:   r_ctrl = ALUadd;
      F_SUB:   r_ctrl = ALUsub;
      F_AND:   r_ctrl = ALUand;
      F_OR:    r_ctrl = ALUor;
      F_SLT:   r_ctrl = ALUslt;
      F_NOR:   r_ctrl = ALUnor;
      F_XOR:   r_ctrl = ALUxor;
      default: r_ctrl = ALUx;
    endcase
    ALU_Control_EX = ALUOp_EX == ALUOP_MEM ? ALUadd :
                     ALUOp_EX == ALUOP_BEQ ? ALUsub :
                     ALUOp_EX == ALUOP_R   ? r_ctrl : ALUx;
    HiLo_Sel_EX    = ALUOp_EX != ALUOP_R ? SEL_ALU :
                     Funct_EX == F_MFHI  ? SEL_HI  :
                     Funct_EX == F_MFLO  ? SEL_LO  : SEL_ALU;
  end
  assign start     = Valid_EX && ALUOp_EX == ALUOP_R && is_muldiv(Funct_EX) && state == IDLE;
  assign is_signed = ~Funct_EX[0];
  assign mag_a     = is_signed && Operand_A_EX[DATA_W-1] ? -Operand_A_EX : Operand_A_EX;
  assign mag_b     = is_signed && Operand_B_EX[DATA_W-1] ? -Operand_B_EX : Operand_B_EX;
  ex_muldiv_iter #(.DATA_W(DATA_W)) u_iter (
    .is_div (is_div),
    .acc    (acc),
    .mc     (mc),
    .mq     (mq),
    .acc_n  (acc_n),
    .mc_n   (mc_n),
    .mq_n   (mq_n)
  );
`ifdef MULDIV_EARLY_OUT_EN
  assign last = cnt == CNT_W'(1) || (!is_div && mq_n == '0);
`else
  assign last = cnt == CNT_W'(1);
`endif
  // a zero divisor yields remainder = |A|, so the remainder sign fix restores raw A
  always_comb begin
    prod   = neg_q ? -acc_n : acc_n;
    res_hi = is_div ? (sign_a ? -acc_n[DATA_W-1:0] : acc_n[DATA_W-1:0]) : prod[2*DATA_W-1:DATA_W];
    res_lo = is_div ? (dz ? '1 : neg_q ? -mq_n : mq_n) : prod[DATA_W-1:0];
    case (state)
      IDLE:    state_n = start ? RUN : IDLE;
      RUN:     state_n = last ? DONE : RUN;
      DONE:    state_n = Advance_EX ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_n;
      done_r <= state == RUN && last;
      if (start) begin
        cnt    <= CNT_W'(DATA_W);
        is_div <= Funct_EX[1];
        sign_a <= is_signed && Operand_A_EX[DATA_W-1];
        neg_q  <= is_signed && (Operand_A_EX[DATA_W-1] ^ Operand_B_EX[DATA_W-1]);
        dz     <= Operand_B_EX == '0;
        acc    <= '0;
        mc     <= {{DATA_W{1'b0}}, Funct_EX[1] ? mag_b : mag_a};
        mq     <= Funct_EX[1] ? mag_a : mag_b;
      end else if (state == RUN) begin
        cnt <= cnt - 1'b1;
        acc <= acc_n;
        mc  <= mc_n;
        mq  <= mq_n;
        if (last) begin
          hi <= res_hi;
          lo <= res_lo;
        end
      end
    end
  end
  assign MulDiv_Busy_EX = start || state == RUN;
  assign MulDiv_Done_EX = done_r;
  assign DivByZero_EX   = done_r && is_div && dz;
  assign HI_EX          = hi;
  assign LO_EX          = lo;
endmodule

// File: tb/tb_ex_alu_muldiv_ctrl.sv
// tb_ex_alu_muldiv_ctrl: directed decode and mul/div checks with an expected-result queue
module tb_ex_alu_muldiv_ctrl;
  localparam int W = 32;
  logic Clk = 1'b0, Reset = 1'b1, Valid_EX = 1'b0, Advance_EX = 1'b0;
  logic [1:0] ALUOp_EX = 2'b00;
  logic [5:0] Funct_EX = 6'b0;
  logic [W-1:0] Operand_A_EX = '0, Operand_B_EX = '0;
  logic [3:0] ALU_Control_EX;
  logic [1:0] HiLo_Sel_EX;
  logic MulDiv_Busy_EX, MulDiv_Done_EX, DivByZero_EX;
  logic [W-1:0] HI_EX, LO_EX;
  int vecs = 0, errs = 0;
  typedef struct {logic dz; logic [W-1:0] hi; logic [W-1:0] lo; int busy;} exp_t;
  exp_t scb[$];

  ex_alu_muldiv_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Valid_EX(Valid_EX), .Advance_EX(Advance_EX),
    .ALUOp_EX(ALUOp_EX), .Funct_EX(Funct_EX), .Operand_A_EX(Operand_A_EX),
    .Operand_B_EX(Operand_B_EX), .ALU_Control_EX(ALU_Control_EX), .HiLo_Sel_EX(HiLo_Sel_EX),
    .MulDiv_Busy_EX(MulDiv_Busy_EX), .MulDiv_Done_EX(MulDiv_Done_EX),
    .DivByZero_EX(DivByZero_EX), .HI_EX(HI_EX), .LO_EX(LO_EX)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sb;
    logic [63:0] u;
    logic [W-1:0] mag;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    e.busy = W + 1;
    case (f)
      6'b011000: begin u = sa * sb; e.hi = u[63:32]; e.lo = u[31:0]; end
      6'b011001: begin u = {32'b0, a} * {32'b0, b}; e.hi = u[63:32]; e.lo = u[31:0]; end
      6'b011010: begin
        if (b == '0) begin e.dz = 1'b1; e.hi = a; e.lo = '1; end
        else begin u = sa / sb; e.lo = u[31:0]; u = sa % sb; e.hi = u[31:0]; end
      end
      default: begin
        if (b == '0) begin e.dz = 1'b1; e.hi = a; e.lo = '1; end
        else begin e.lo = a / b; e.hi = a % b; end
      end
    endcase
`ifdef MULDIV_EARLY_OUT_EN
    if (!f[1]) begin
      mag = (!f[0] && b[W-1]) ? -b : b;
      e.busy = 2;
      for (int i = 0; i < W; i++) if (mag[i]) e.busy = i + 2;
    end
`endif
    return e;
  endfunction

  task automatic dec(input logic [1:0] op, input logic [5:0] f, input logic [3:0] ctrl, input logic [1:0] sel);
    @(negedge Clk);
    ALUOp_EX = op;
    Funct_EX = f;
    #1;
    check($sformatf("dec %b/%b ctrl", op, f), ALU_Control_EX, ctrl);
    check($sformatf("dec %b/%b sel", op, f), HiLo_Sel_EX, sel);
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    exp_t e;
    int n, busy;
    scb.push_back(model(f, a, b));
    @(negedge Clk);
    Valid_EX = 1'b1; ALUOp_EX = 2'b10; Funct_EX = f;
    Operand_A_EX = a; Operand_B_EX = b; Advance_EX = (hold == 0);
    #1;
    n = 0;
    busy = 0;
    while (!MulDiv_Done_EX && n < 200) begin
      if (MulDiv_Busy_EX) busy++;
      @(negedge Clk);
      if (hold == 0) Valid_EX = 1'b0;
      #1;
      n++;
    end
    e = scb.pop_front();
    check({tag, " done"}, MulDiv_Done_EX, 1);
    check({tag, " busy cycles"}, busy, e.busy);
    check({tag, " done latency"}, n, e.busy);
    check({tag, " busy in done"}, MulDiv_Busy_EX, 0);
    check({tag, " dz"}, DivByZero_EX, e.dz);
    check({tag, " hi"}, HI_EX, e.hi);
    check({tag, " lo"}, LO_EX, e.lo);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      #1;
      check({tag, " hold done"}, MulDiv_Done_EX, 0);
      check({tag, " hold busy"}, MulDiv_Busy_EX, 0);
    end
    @(negedge Clk);
    Advance_EX = 1'b1;
    Valid_EX = 1'b0;
    @(negedge Clk);
    #1;
    check({tag, " idle busy"}, MulDiv_Busy_EX, 0);
    check({tag, " idle done"}, MulDiv_Done_EX, 0);
    check({tag, " hi held"}, HI_EX, e.hi);
    check({tag, " lo held"}, LO_EX, e.lo);
  endtask

  initial begin
    repeat (2) @(negedge Clk);
    #1;
    check("rst busy", MulDiv_Busy_EX, 0);
    check("rst done", MulDiv_Done_EX, 0);
    check("rst dz", DivByZero_EX, 0);
    check("rst hi", HI_EX, 0);
    check("rst lo", LO_EX, 0);
    Reset = 1'b0;
    dec(2'b10, 6'b100111, 4'b1100, 2'b00);
    dec(2'b10, 6'b100110, 4'b1101, 2'b00);
    dec(2'b10, 6'b111111, 4'b0011, 2'b00);
    dec(2'b10, 6'b100000, 4'b0010, 2'b00);
    dec(2'b10, 6'b100010, 4'b0110, 2'b00);
    dec(2'b10, 6'b100100, 4'b0000, 2'b00);
    dec(2'b10, 6'b100101, 4'b0001, 2'b00);
    dec(2'b10, 6'b101010, 4'b0111, 2'b00);
    dec(2'b00, 6'b100110, 4'b0010, 2'b00);
    dec(2'b01, 6'b100100, 4'b0110, 2'b00);
    dec(2'b11, 6'b100000, 4'b0011, 2'b00);
    dec(2'b10, 6'b010010, 4'b0011, 2'b10);
    dec(2'b10, 6'b010000, 4'b0011, 2'b01);
    dec(2'b01, 6'b010000, 4'b0110, 2'b00);
    run_op("mult", 6'b011000, 32'hFFFFFFFD, 32'h00000007, 0);
    run_op("divu", 6'b011011, 32'd100, 32'd7, 0);
    run_op("div neg", 6'b011010, 32'hFFFFFFF9, 32'h00000002, 0);
    run_op("div min", 6'b011010, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("div zero", 6'b011010, 32'h00000005, 32'h00000000, 0);
    run_op("divu zero", 6'b011011, 32'h80000003, 32'h00000000, 0);
    run_op("div negzero", 6'b011010, 32'hFFFFFFF0, 32'h00000000, 0);
    run_op("multu big", 6'b011001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    @(negedge Clk);
    Valid_EX = 1'b1; ALUOp_EX = 2'b10; Funct_EX = 6'b011001;
    Operand_A_EX = 32'd5; Operand_B_EX = 32'hFFFFFFFF; Advance_EX = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      Valid_EX = 1'b0;
    end
    #1;
    check("run10 busy", MulDiv_Busy_EX, 1);
    Reset = 1'b1;
    @(negedge Clk);
    #1;
    check("abort busy", MulDiv_Busy_EX, 0);
    check("abort done", MulDiv_Done_EX, 0);
    check("abort hi", HI_EX, 0);
    check("abort lo", LO_EX, 0);
    Reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      #1;
      check("abort no done", MulDiv_Done_EX, 0);
    end
    run_op("multu 2x3", 6'b011001, 32'd2, 32'd3, 0);
    run_op("multu hold", 6'b011001, 32'd5, 32'd3, 2);
    check("scoreboard empty", scb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
